// File: rtl/skew_tile_feeder_if.sv
// Row-write and column-stream signals between a tile source, the feeder and the skew buffer.
// The feeder connects through the slave modport and the tile source through the master modport.
interface skew_tile_feeder_if #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 32
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATAWIDTH-1:0] wr_data [N_SIZE];
  logic                 start;
  logic                 busy;
  logic                 tile_loaded;
  logic                 valid_out;
  logic [DATAWIDTH-1:0] out_A [N_SIZE];
  logic                 tile_done;

  modport slave (
    input  wr_valid, wr_data, start,
    output wr_ready, busy, tile_loaded, valid_out, out_A, tile_done
  );

  modport master (
    output wr_valid, wr_data, start,
    input  wr_ready, busy, tile_loaded, valid_out, out_A, tile_done
  );
endinterface

// File: rtl/skew_tile_feeder.sv
// Stores an N_SIZE x N_SIZE A tile row by row, then streams it column by column plus N_SIZE-1 zero drain vectors.
// Build option SKEW_FEEDER_PINGPONG_EN adds a second tile bank so loading overlaps streaming.
module skew_tile_feeder #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 32
) (
  input logic               clk,
  input logic               rst_n,
  skew_tile_feeder_if.slave bus
);

  localparam int CW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(N_SIZE - 1);
  localparam logic [CW-1:0] DLAST = CW'(N_SIZE - 2);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM, S_DRAIN} state_t;

  state_t               r_state, w_nxt_state;
  logic [CW-1:0]        r_row;
  logic [CW-1:0]        r_cnt, w_nxt_cnt;
  logic                 r_valid, w_nxt_valid;
  logic                 r_done, w_nxt_done;
  logic [DATAWIDTH-1:0] r_out [N_SIZE];
  logic [DATAWIDTH-1:0] w_nxt_out [N_SIZE];
  logic                 w_emit_col;
  logic                 w_tile_end;
  logic                 w_wr_ready;
  logic                 w_wr_fire;
  logic                 w_row_last;

`ifdef SKEW_FEEDER_PINGPONG_EN
  logic [DATAWIDTH-1:0] r_mem [2][N_SIZE][N_SIZE];
  logic [1:0]           r_full;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic                 w_rd_bank;
  logic                 w_nb;
  logic                 w_tile_loaded;

  assign w_wr_ready = !r_full[r_wr_bank];
  // A bank stays full until its last column has been read, so it is never overwritten mid-stream.
  assign w_tile_loaded = (r_full[0] && !(r_state == S_STREAM && !r_rd_bank)) ||
                         (r_full[1] && !(r_state == S_STREAM &&  r_rd_bank));
  assign w_nb = (r_state == S_STREAM) ? ~r_rd_bank : r_rd_bank;
`else
  logic [DATAWIDTH-1:0] r_mem [N_SIZE][N_SIZE];

  assign w_wr_ready = (r_state == S_LOAD);
`endif

  assign w_wr_fire  = bus.wr_valid && w_wr_ready;
  assign w_row_last = (r_row == LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_valid = 1'b0;
    w_nxt_done  = 1'b0;
    w_emit_col  = 1'b0;
    w_tile_end  = 1'b0;
`ifdef SKEW_FEEDER_PINGPONG_EN
    w_rd_bank   = r_rd_bank;
`endif
    unique case (r_state)
      S_LOAD: begin
        if (w_wr_fire && w_row_last) w_nxt_state = S_READY;
      end
      S_READY: begin
        if (bus.start) begin
          w_nxt_state = S_STREAM;
          w_nxt_cnt   = '0;
          w_nxt_valid = 1'b1;
          w_emit_col  = 1'b1;
          w_nxt_done  = (N_SIZE == 1);
        end
      end
      S_STREAM: begin
        if (r_cnt == LAST) begin
          if (N_SIZE == 1) begin
            w_tile_end = 1'b1;
          end else begin
            w_nxt_state = S_DRAIN;
            w_nxt_cnt   = '0;
            w_nxt_valid = 1'b1;
            w_nxt_done  = (N_SIZE == 2);
          end
        end else begin
          w_nxt_cnt   = r_cnt + CW'(1);
          w_nxt_valid = 1'b1;
          w_emit_col  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DLAST) begin
          w_tile_end = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CW'(1);
          w_nxt_valid = 1'b1;
          w_nxt_done  = ((r_cnt + CW'(1)) == DLAST);
        end
      end
      default: w_nxt_state = S_LOAD;
    endcase

    if (w_tile_end) begin
      w_nxt_cnt   = '0;
      w_nxt_state = S_LOAD;
`ifdef SKEW_FEEDER_PINGPONG_EN
      // Back-to-back only from a bank whose rows are all in storage already; a bank finishing this edge waits in READY.
      if (r_full[w_nb] && bus.start) begin
        w_nxt_state = S_STREAM;
        w_nxt_valid = 1'b1;
        w_emit_col  = 1'b1;
        w_nxt_done  = (N_SIZE == 1);
        w_rd_bank   = w_nb;
      end else if (r_full[w_nb] || (w_wr_fire && w_row_last && (r_wr_bank == w_nb))) begin
        w_nxt_state = S_READY;
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < N_SIZE; i++) begin
      w_nxt_out[i] = '0;
`ifdef SKEW_FEEDER_PINGPONG_EN
      if (w_emit_col) w_nxt_out[i] = r_mem[w_rd_bank][i][w_nxt_cnt];
`else
      if (w_emit_col) w_nxt_out[i] = r_mem[i][w_nxt_cnt];
`endif
    end
  end

  // Tile storage carries no reset; its contents are only read after a full tile has been written.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int k = 0; k < N_SIZE; k++) begin
`ifdef SKEW_FEEDER_PINGPONG_EN
        r_mem[r_wr_bank][r_row][k] <= bus.wr_data[k];
`else
        r_mem[r_row][k] <= bus.wr_data[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_row   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < N_SIZE; i++) r_out[i] <= '0;
`ifdef SKEW_FEEDER_PINGPONG_EN
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_valid <= w_nxt_valid;
      r_done  <= w_nxt_done;
      r_out   <= w_nxt_out;
      if (w_wr_fire) r_row <= w_row_last ? '0 : r_row + CW'(1);
`ifdef SKEW_FEEDER_PINGPONG_EN
      if (w_wr_fire && w_row_last) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (r_state == S_STREAM && r_cnt == LAST) begin
        r_full[r_rd_bank] <= 1'b0;
      end
      if (w_nxt_state == S_STREAM && r_state != S_STREAM) begin
        r_rd_bank <= w_rd_bank;
      end else if (r_state == S_STREAM && r_cnt == LAST) begin
        r_rd_bank <= ~r_rd_bank;
      end
`endif
    end
  end

  assign bus.wr_ready  = w_wr_ready;
`ifdef SKEW_FEEDER_PINGPONG_EN
  assign bus.tile_loaded = w_tile_loaded;
`else
  assign bus.tile_loaded = (r_state == S_READY);
`endif
  assign bus.valid_out = r_valid;
  assign bus.busy      = r_valid;
  assign bus.tile_done = r_done;
  assign bus.out_A     = r_out;

endmodule
